fetch_unit_ras: RTL and testbench

Parametrised instruction-fetch stage with an integrated circular return-address stack (RAS), stall support and a registered IF/ID output latch. It owns the PC and drives the external instruction memory address. It resolves redirects from decode (jump, call, call-via-rs1, return, taken BEQ/BNE) and injects a bubble into decode on every taken redirect.

---
 rtl/fetch_pkg.sv | 38 +++
 rtl/return_addr_stack.sv | 71 +++++++
 rtl/fetch_unit_ras.sv | 121 ++++++++++++
 tb/tb_fetch_unit_ras.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch stage: next-PC source encoding and
// the redirect priority resolver used by the fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_JUMP,
    PC_BRANCH,
    PC_CALL_RS1,
    PC_RET
  } pc_src_e;

  localparam int unsigned FETCH_INC = 4;

  // Multi-hot decode signals resolve as ret > call_rs1 > call > jump > branch.
  // Plain calls share PC_JUMP with jumps because both target jump_addr.
  function automatic pc_src_e pc_select(
    input logic sig_ret,
    input logic sig_call_rs1,
    input logic sig_call,
    input logic sig_jump,
    input logic sig_beq,
    input logic sig_bne,
    input logic sig_eq
  );
    if (sig_ret) begin
      return PC_RET;
    end else if (sig_call_rs1) begin
      return PC_CALL_RS1;
    end else if (sig_call || sig_jump) begin
      return PC_JUMP;
    end else if ((sig_beq && sig_eq) || (sig_bne && !sig_eq)) begin
      return PC_BRANCH;
    end
    return PC_SEQ;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// pops on an empty stack leave the pointer alone and flag an underflow.
module return_addr_stack #(
  parameter  int XLEN      = 32,
  parameter  int RAS_DEPTH = 8,
  localparam int PTR_W     = $clog2(RAS_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [XLEN-1:0]  push_data,
  output logic [XLEN-1:0]  top_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             full;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign top_data  = mem_q[top_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    if (push) begin
      top_d = top_q + PTR_W'(1);
      if (!full) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      top_q       <= top_d;
      count_q     <= count_d;
      overflow_q  <= push && full;
      underflow_q <= pop && !push && empty;
    end
  end

  // Storage is never cleared; entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[top_d] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit_ras.sv
// Instruction fetch stage: PC register, prioritised next-PC selection with a
// return-address stack, one-bubble redirect kill and the IF/ID output latch.
module fetch_unit_ras
  import fetch_pkg::*;
#(
  parameter  int              XLEN      = 32,
  parameter  int              RAS_DEPTH = 8,
  parameter  logic [XLEN-1:0] RESET_PC  = '0,
  parameter  logic [XLEN-1:0] NOP_INSTR = '0,
  localparam int              CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic [XLEN-1:0]  jump_addr,
  input  logic [XLEN-1:0]  branch_addr,
  input  logic [XLEN-1:0]  call_rs1_addr,
  input  logic [XLEN-1:0]  id_link_pc4,
  input  logic             sig_jump,
  input  logic             sig_call,
  input  logic             sig_call_rs1,
  input  logic             sig_ret,
  input  logic             sig_beq,
  input  logic             sig_bne,
  input  logic             sig_eq,
  output logic [XLEN-1:0]  id_instr,
  output logic [XLEN-1:0]  id_pc4,
  output logic             id_valid,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_push, ras_pop;
  logic            redirect;
  pc_src_e         pc_src;

  assign pc_src   = pc_select(sig_ret, sig_call_rs1, sig_call, sig_jump,
                              sig_beq, sig_bne, sig_eq);
  assign redirect = (pc_src != PC_SEQ);
  assign pc_plus4 = pc_q + XLEN'(FETCH_INC);

  // A call shows up as PC_JUMP; sig_call distinguishes it since call beats jump.
  assign ras_push = !stall && ((pc_src == PC_CALL_RS1) || (pc_src == PC_JUMP && sig_call));
  assign ras_pop  = !stall && (pc_src == PC_RET);

  always_comb begin
    target = pc_plus4;
    unique case (pc_src)
      PC_RET:      target = ras_empty ? RESET_PC : ras_top;
      PC_CALL_RS1: target = call_rs1_addr;
      PC_JUMP:     target = jump_addr;
      PC_BRANCH:   target = branch_addr;
      default:     target = pc_plus4;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    if (!stall) begin
      pc_d     = target;
      id_pc4_d = pc_plus4;
      if (redirect) begin
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end else begin
        id_instr_d = imem_rdata;
        id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_instr_q <= NOP_INSTR;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  return_addr_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (id_link_pc4),
    .top_data  (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign imem_addr = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;

endmodule

// File: tb/tb_fetch_unit_ras.sv
// Directed vector table plus randomized run against a queue-based reference
// model of the fetch stage and its return-address stack.
module tb_fetch_unit_ras;

  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // sig field layout: {ret, call_rs1, call, jump, beq, bne, eq}
  localparam logic [6:0] S_RET  = 7'b1000000;
  localparam logic [6:0] S_CRS1 = 7'b0100000;
  localparam logic [6:0] S_CALL = 7'b0010000;
  localparam logic [6:0] S_JMP  = 7'b0001000;
  localparam logic [6:0] S_BEQ  = 7'b0000100;
  localparam logic [6:0] S_BNE  = 7'b0000010;
  localparam logic [6:0] S_EQ   = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] jump_addr, branch_addr, call_rs1_addr, id_link_pc4;
  logic        sig_jump, sig_call, sig_call_rs1, sig_ret, sig_beq, sig_bne, sig_eq;
  logic [31:0] id_instr, id_pc4;
  logic        id_valid;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  assign imem_rdata = imem_fn(imem_addr);

  fetch_unit_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .jump_addr     (jump_addr),
    .branch_addr   (branch_addr),
    .call_rs1_addr (call_rs1_addr),
    .id_link_pc4   (id_link_pc4),
    .sig_jump      (sig_jump),
    .sig_call      (sig_call),
    .sig_call_rs1  (sig_call_rs1),
    .sig_ret       (sig_ret),
    .sig_beq       (sig_beq),
    .sig_bne       (sig_bne),
    .sig_eq        (sig_eq),
    .id_instr      (id_instr),
    .id_pc4        (id_pc4),
    .id_valid      (id_valid),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  typedef struct {
    bit          rst;
    bit          stl;
    logic [6:0]  sig;
    logic [31:0] ja, ba, ca, lk;
    logic [31:0] e_addr, e_instr, e_pc4;
    bit          e_valid;
    int          e_cnt;
    bit          e_ovf, e_unf;
  } vec_t;

  vec_t vt[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid, m_ovf, m_unf;
  logic [31:0] m_ras[$];

  function automatic vec_t mk(bit rst, bit stl, logic [6:0] sig,
                              logic [31:0] ja, logic [31:0] ba, logic [31:0] ca, logic [31:0] lk,
                              logic [31:0] e_addr, logic [31:0] e_instr, logic [31:0] e_pc4,
                              bit e_valid, int e_cnt, bit e_ovf, bit e_unf);
    vec_t v;
    v.rst = rst; v.stl = stl; v.sig = sig;
    v.ja = ja; v.ba = ba; v.ca = ca; v.lk = lk;
    v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    v.e_valid = e_valid; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit stl, input logic [6:0] sig,
                       input logic [31:0] ja, input logic [31:0] ba,
                       input logic [31:0] ca, input logic [31:0] lk);
    reset = rst; stall = stl;
    {sig_ret, sig_call_rs1, sig_call, sig_jump, sig_beq, sig_bne, sig_eq} = sig;
    jump_addr = ja; branch_addr = ba; call_rs1_addr = ca; id_link_pc4 = lk;
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_edge();
    logic [31:0] tgt;
    bit          redir;
    bit          taken_br;
    if (reset) begin
      m_pc = RST_PC; m_instr = NOP; m_pc4 = 0; m_valid = 0;
      m_ovf = 0; m_unf = 0;
      m_ras.delete();
    end else if (stall) begin
      m_ovf = 0; m_unf = 0;
    end else begin
      m_ovf = 0; m_unf = 0;
      taken_br = (sig_beq && sig_eq) || (sig_bne && !sig_eq);
      redir = 1; tgt = 0;
      if (sig_ret) begin
        if (m_ras.size() > 0) tgt = m_ras.pop_back();
        else begin tgt = RST_PC; m_unf = 1; end
      end else if (sig_call_rs1 || sig_call) begin
        tgt = sig_call_rs1 ? call_rs1_addr : jump_addr;
        m_ras.push_back(id_link_pc4);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
      end else if (sig_jump) tgt = jump_addr;
      else if (taken_br) tgt = branch_addr;
      else redir = 0;
      m_pc4 = m_pc + 32'd4;
      if (redir) begin m_instr = NOP; m_valid = 0; end
      else begin m_instr = imem_fn(m_pc); m_valid = 1; end
      m_pc = redir ? tgt : m_pc + 32'd4;
    end
  endtask

  initial begin
    drive(1, 0, 7'b0, 0, 0, 0, 0);

    //      rst stl sig                      ja            ba     ca     lk     addr          instr         pc4    v cnt o u
    vt.push_back(mk(1, 0, 7'b0,              0,            0,     0,     0,     32'h0,        NOP,          32'h0,   0, 0, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h4,        32'h11,       32'h4,   1, 0, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h8,        32'h22,       32'h8,   1, 0, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'hC,        32'h33,       32'hC,   1, 0, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h10,       32'h44,       32'h10,  1, 0, 0, 0));
    vt.push_back(mk(0, 0, S_BEQ|S_EQ,        0,            32'h100, 0,   0,     32'h100,      NOP,          32'h14,  0, 0, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h104,      32'h451,      32'h104, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, S_JMP,             32'h10,       0,     0,     0,     32'h10,       NOP,          32'h108, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, S_BEQ,             0,            32'h100, 0,   0,     32'h14,       32'h55,       32'h14,  1, 0, 0, 0));
    vt.push_back(mk(0, 0, S_CALL,            32'h200,      0,     0,     32'hC, 32'h200,      NOP,          32'h18,  0, 1, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h204,      32'h891,      32'h204, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, S_RET,             0,            0,     0,     0,     32'hC,        NOP,          32'h208, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, S_CALL,            32'h200,      0,     0,     32'h10, 32'h200,     NOP,          32'h10,  0, 1, 0, 0));
    vt.push_back(mk(0, 0, S_CRS1,            0,            0,     32'h300, 32'h20, 32'h300,   NOP,          32'h204, 0, 2, 0, 0));
    vt.push_back(mk(0, 0, S_CALL,            32'h200,      0,     0,     32'h30, 32'h200,     NOP,          32'h304, 0, 3, 0, 0));
    vt.push_back(mk(0, 0, S_CALL,            32'h200,      0,     0,     32'h40, 32'h200,     NOP,          32'h204, 0, 4, 0, 0));
    vt.push_back(mk(0, 0, S_CALL,            32'h200,      0,     0,     32'h50, 32'h200,     NOP,          32'h204, 0, 4, 1, 0));
    vt.push_back(mk(0, 0, S_RET,             0,            0,     0,     0,     32'h50,       NOP,          32'h204, 0, 3, 0, 0));
    vt.push_back(mk(0, 0, S_RET,             0,            0,     0,     0,     32'h40,       NOP,          32'h54,  0, 2, 0, 0));
    vt.push_back(mk(0, 0, S_RET,             0,            0,     0,     0,     32'h30,       NOP,          32'h44,  0, 1, 0, 0));
    vt.push_back(mk(0, 0, S_RET,             0,            0,     0,     0,     32'h20,       NOP,          32'h34,  0, 0, 0, 0));
    vt.push_back(mk(0, 0, S_RET,             0,            0,     0,     0,     RST_PC,       NOP,          32'h24,  0, 0, 0, 1));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h4,        32'h11,       32'h4,   1, 0, 0, 0));
    vt.push_back(mk(0, 0, S_CALL,            32'h200,      0,     0,     32'h70, 32'h200,     NOP,          32'h8,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, S_CALL,            32'h200,      0,     0,     32'h74, 32'h200,     NOP,          32'h204, 0, 2, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h204,      32'h891,      32'h204, 1, 2, 0, 0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(0, 1, S_JMP,           32'h400,      0,     0,     0,     32'h204,      32'h891,      32'h204, 1, 2, 0, 0));
    vt.push_back(mk(0, 0, S_JMP,             32'h400,      0,     0,     0,     32'h400,      NOP,          32'h208, 0, 2, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h404,      32'h1111,     32'h404, 1, 2, 0, 0));
    vt.push_back(mk(1, 1, S_CALL,            32'h200,      0,     0,     32'h99, RST_PC,      NOP,          32'h0,   0, 0, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h4,        32'h11,       32'h4,   1, 0, 0, 0));
    vt.push_back(mk(0, 0, S_RET,             0,            0,     0,     0,     RST_PC,       NOP,          32'h8,   0, 0, 0, 1));
    vt.push_back(mk(0, 0, S_CALL|S_JMP|S_BEQ|S_EQ, 32'h500, 32'h600, 0, 32'h77, 32'h500,    NOP,          32'h4,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, S_RET|S_CRS1|S_CALL, 32'h500,    0,     32'h300, 32'h99, 32'h77,    NOP,          32'h504, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, S_CRS1|S_CALL|S_JMP, 32'h500,    0,     32'h300, 32'h88, 32'h300,   NOP,          32'h7B,  0, 1, 0, 0));
    vt.push_back(mk(0, 0, S_JMP,             32'hFFFF_FFFC, 0,    0,     0,     32'hFFFF_FFFC, NOP,         32'h304, 0, 1, 0, 0));
    vt.push_back(mk(0, 0, 7'b0,              0,            0,     0,     0,     32'h0,        32'h4000_0000, 32'h0,  1, 1, 0, 0));

    @(negedge clk);
    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].stl, vt[i].sig, vt[i].ja, vt[i].ba, vt[i].ca, vt[i].lk);
      @(posedge clk);
      #1;
      $display("vec %0d: addr=%08h instr=%08h pc4=%08h v=%0b cnt=%0d ovf=%0b unf=%0b",
               i, imem_addr, id_instr, id_pc4, id_valid, ras_count, ras_overflow, ras_underflow);
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d id_instr", i), id_instr, vt[i].e_instr);
      chk($sformatf("vec%0d id_pc4", i), id_pc4, vt[i].e_pc4);
      chk($sformatf("vec%0d id_valid", i), {31'b0, id_valid}, {31'b0, vt[i].e_valid});
      chk($sformatf("vec%0d ras_count", i), {29'b0, ras_count}, 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d ras_overflow", i), {31'b0, ras_overflow}, {31'b0, vt[i].e_ovf});
      chk($sformatf("vec%0d ras_underflow", i), {31'b0, ras_underflow}, {31'b0, vt[i].e_unf});
    end

    // Randomized run against the reference model, starting from reset.
    for (int c = 0; c < 400; c++) begin
      logic [6:0]  sig;
      logic [31:0] ja, ba, ca, lk;
      sig = '0;
      for (int b = 0; b < 7; b++)
        sig[b] = ($urandom_range(0, 5) == 0);
      sig[0] = $urandom_range(0, 1);
      ja = {$urandom_range(0, 255), 2'b00};
      ba = {$urandom_range(0, 255), 2'b00};
      ca = {$urandom_range(0, 255), 2'b00};
      lk = $urandom;
      drive((c == 0) || ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
            sig, ja, ba, ca, lk);
      model_edge();
      @(posedge clk);
      #1;
      $display("rnd %0d: addr=%08h instr=%08h v=%0b cnt=%0d", c, imem_addr, id_instr, id_valid, ras_count);
      chk($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);
      chk($sformatf("rnd%0d id_instr", c), id_instr, m_instr);
      chk($sformatf("rnd%0d id_pc4", c), id_pc4, m_pc4);
      chk($sformatf("rnd%0d id_valid", c), {31'b0, id_valid}, {31'b0, m_valid});
      chk($sformatf("rnd%0d ras_count", c), {29'b0, ras_count}, 32'(m_ras.size()));
      chk($sformatf("rnd%0d ras_overflow", c), {31'b0, ras_overflow}, {31'b0, m_ovf});
      chk($sformatf("rnd%0d ras_underflow", c), {31'b0, ras_underflow}, {31'b0, m_unf});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
